// File: rtl/frame_pkg.sv
// Shared types and constants for the frame deserializer slice.
package frame_pkg;

   typedef enum logic {
      HUNT  = 1'b0,
      SHIFT = 1'b1
   } frame_state_t;

   localparam int WORD_W_DEF = 4;
   localparam int ADDR_W_DEF = 10;
   localparam int ERR_CNT_W  = 8;

endpackage : frame_pkg

// File: rtl/frame_sync_check.sv
// Framing checker: flags a sync pulse arriving mid-word (early) or missing
// at a word boundary (late), and keeps a one-cycle error pulse plus a
// saturating error count.
module frame_sync_check
   import frame_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_shift,
   input  logic                 i_frame_sync,
   input  logic                 i_cnt_zero,
   output logic                 o_early,
   output logic                 o_late,
   output logic                 o_sync_err,
   output logic [ERR_CNT_W-1:0] o_err_cnt
);

   logic                 r_sync_err;
   logic [ERR_CNT_W-1:0] r_err_cnt;
   logic                 w_err;

   assign o_early = i_shift &  i_frame_sync & ~i_cnt_zero;
   assign o_late  = i_shift & ~i_frame_sync &  i_cnt_zero;
   assign w_err   = o_early | o_late;

   // Error pulse lands one cycle after the offending sample; count saturates.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync_err <= 1'b0;
         r_err_cnt  <= '0;
      end else begin
         r_sync_err <= w_err;
         if (w_err && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign o_sync_err = r_sync_err;
   assign o_err_cnt  = r_err_cnt;

endmodule : frame_sync_check

// File: rtl/frame_deserializer.sv
// Serial-to-word deserializer feeding a BRAM write port. Frames are
// delimited by frame_sync on the MSB; words are written at incrementing
// addresses one cycle after their last bit.
// Optional framing check enabled by defining FRAME_SYNC_CHECK_EN.
module frame_deserializer
   import frame_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ser_in,
   input  logic                 frame_sync,
   output logic                 wr_en,
   output logic [ADDR_W-1:0]    wr_addr,
   output logic [WORD_W-1:0]    wr_data,
   output logic                 locked,
   output logic                 wrap,
   output logic                 sync_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

   frame_state_t      r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [WORD_W-1:0] r_sr;
   logic [ADDR_W-1:0] r_ptr;
   logic              r_wr_en, r_wrap, r_locked;
   logic [WORD_W-1:0] r_wr_data;
   logic              w_load, w_shift, w_done;
   logic              w_early, w_late;
   logic [WORD_W-1:0] w_sr_shift;

   assign w_sr_shift = {r_sr[WORD_W-2:0], ser_in};

`ifdef FRAME_SYNC_CHECK_EN
   frame_sync_check u_chk (
      .clk          (clk),
      .rst          (rst),
      .i_shift      (r_state == SHIFT),
      .i_frame_sync (frame_sync),
      .i_cnt_zero   (r_bit_cnt == '0),
      .o_early      (w_early),
      .o_late       (w_late),
      .o_sync_err   (sync_err),
      .o_err_cnt    (err_cnt)
   );
`else
   assign w_early  = 1'b0;
   assign w_late   = 1'b0;
   assign sync_err = 1'b0;
   assign err_cnt  = '0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= HUNT;
      else     r_state <= w_state_nxt;
   end

   // Next state and datapath controls; an early sync restarts the word in place.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         HUNT: begin
            if (frame_sync) begin
               w_load      = 1'b1;
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (w_early) begin
               w_load = 1'b1;
            end else if (w_late) begin
               w_state_nxt = HUNT;
            end else begin
               w_shift = 1'b1;
               w_done  = (r_bit_cnt == LAST_BIT);
            end
         end
         default: w_state_nxt = HUNT;
      endcase
   end

   // Shift register, bit counter, write port and pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sr      <= '0;
         r_bit_cnt <= '0;
         r_ptr     <= '0;
         r_wr_en   <= 1'b0;
         r_wrap    <= 1'b0;
         r_wr_data <= '0;
         r_locked  <= 1'b0;
      end else begin
         r_wr_en <= w_done;
         r_wrap  <= w_done && (r_ptr == '1);
         if (w_done)  r_wr_data <= w_sr_shift;
         if (r_wr_en) r_ptr     <= r_ptr + 1'b1;

         if (w_load) begin
            r_sr      <= {{(WORD_W-1){1'b0}}, ser_in};
            r_bit_cnt <= CNT_W'(1);
         end else if (w_shift) begin
            r_sr      <= w_sr_shift;
            r_bit_cnt <= w_done ? '0 : r_bit_cnt + 1'b1;
         end

         if (w_early || w_late) r_locked <= 1'b0;
         else if (w_done)       r_locked <= 1'b1;
      end
   end

   assign wr_en   = r_wr_en;
   assign wr_addr = r_ptr;
   assign wr_data = r_wr_data;
   assign wrap    = r_wrap;
   assign locked  = r_locked;

endmodule : frame_deserializer

// File: tb/tb_frame_deserializer.sv
// Randomized bench for frame_deserializer. Two instances (ADDR_W=10 and
// ADDR_W=2) share one stimulus stream; a queue-based frame model predicts
// every output after each clock edge.
module tb_frame_deserializer;
   import frame_pkg::*;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst, ser_in, frame_sync;

   logic         wr_en_a, wr_en_b, locked_a, locked_b, wrap_a, wrap_b;
   logic         serr_a, serr_b;
   logic [9:0]   addr_a;
   logic [1:0]   addr_b;
   logic [W-1:0] data_a, data_b;
   logic [7:0]   ecnt_a, ecnt_b;

   frame_deserializer #(.WORD_W(W), .ADDR_W(10)) u_dut_a (
      .clk(clk), .rst(rst), .ser_in(ser_in), .frame_sync(frame_sync),
      .wr_en(wr_en_a), .wr_addr(addr_a), .wr_data(data_a), .locked(locked_a),
      .wrap(wrap_a), .sync_err(serr_a), .err_cnt(ecnt_a));

   frame_deserializer #(.WORD_W(W), .ADDR_W(2)) u_dut_b (
      .clk(clk), .rst(rst), .ser_in(ser_in), .frame_sync(frame_sync),
      .wr_en(wr_en_b), .wr_addr(addr_b), .wr_data(data_b), .locked(locked_b),
      .wrap(wrap_b), .sync_err(serr_b), .err_cnt(ecnt_b));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %0d exp %0d", tag, cyc, got, exp);
      end
   endtask

   // Reference model: bits of the current frame collected in a queue.
   bit q[$];
   bit framing = 0;
   int wcount  = 0;
   int errs    = 0;
   bit e_wr_en = 0, e_wrap_a = 0, e_wrap_b = 0, e_locked = 0, e_serr = 0;
   int e_data  = 0;

   task automatic model(input bit r, input bit fs, input bit sd);
      bit done = 0;
      bit err  = 0;
      int word = 0;
      if (r) begin
         q.delete(); framing = 0; wcount = 0; errs = 0;
         e_wr_en = 0; e_wrap_a = 0; e_wrap_b = 0; e_locked = 0; e_serr = 0; e_data = 0;
         return;
      end
      if (e_wr_en) wcount++;
      if (!framing) begin
         if (fs) begin q.delete(); q.push_back(sd); framing = 1; end
      end else begin
`ifdef FRAME_SYNC_CHECK_EN
         if (fs && q.size() != 0) begin
            err = 1; q.delete(); q.push_back(sd);
         end else if (!fs && q.size() == 0) begin
            err = 1; framing = 0;
         end else
`endif
         begin
            q.push_back(sd);
            if (q.size() == W) begin
               done = 1;
               foreach (q[i]) word = (word << 1) | int'(q[i]);
               q.delete();
            end
         end
      end
      e_wr_en  = done;
      if (done) e_data = word;
      e_wrap_a = done && (wcount % 1024 == 1023);
      e_wrap_b = done && (wcount % 4 == 3);
      e_serr   = err;
      if (err) errs++;
      if (err) e_locked = 0;
      else if (done) e_locked = 1;
   endtask

   task automatic cycle(input bit r, input bit fs, input bit sd);
      rst = r; frame_sync = fs; ser_in = sd;
      model(r, fs, sd);
      @(posedge clk);
      #1;
      cyc++;
      chk("wr_en_a",  wr_en_a,  e_wr_en);
      chk("wr_en_b",  wr_en_b,  e_wr_en);
      chk("addr_a",   addr_a,   wcount % 1024);
      chk("addr_b",   addr_b,   wcount % 4);
      chk("data_a",   data_a,   e_data);
      chk("data_b",   data_b,   e_data);
      chk("wrap_a",   wrap_a,   e_wrap_a);
      chk("wrap_b",   wrap_b,   e_wrap_b);
      chk("locked_a", locked_a, e_locked);
      chk("locked_b", locked_b, e_locked);
      chk("serr_a",   serr_a,   e_serr);
      chk("ecnt_a",   ecnt_a,   (errs > 255) ? 255 : errs);
      chk("ecnt_b",   ecnt_b,   (errs > 255) ? 255 : errs);
   endtask

   // One frame, MSB first; optional sync on the MSB.
   task automatic send_word(input int w, input bit with_sync);
      for (int i = W - 1; i >= 0; i--)
         cycle(1'b0, with_sync && (i == W - 1), w[i]);
   endtask

   initial begin
      rst = 1'b1; frame_sync = 1'b0; ser_in = 1'b0;
      // Reset state, with a sync pulse that reset must override.
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1);

      // Basic capture.
      send_word(4'hA, 1'b1);
      send_word(4'h5, 1'b1);
      send_word(4'hF, 1'b1);
      // Address wrap on the narrow instance.
      for (int k = 0; k < 6; k++) send_word(int'($urandom_range(15)), 1'b1);

      // Early sync after two bits, then the restarted word completes.
      cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0);
      send_word(4'h6, 1'b1);
      send_word(4'h9, 1'b1);

      // Missing sync, idle, then resume.
      send_word(4'h3, 1'b0);
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1);
      send_word(4'hC, 1'b1);
      send_word(4'h7, 1'b1);

      // Reset mid-word, then next frame lands at address 0.
      cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1);
      send_word(4'hB, 1'b1);
      send_word(4'h4, 1'b1);

      // Continuous sync: an early error every cycle, counter saturates.
      for (int k = 0; k < 300; k++) cycle(1'b0, 1'b1, 1'($urandom_range(1)));
      send_word(4'h2, 1'b1);

      // Random mix of good, dropped-sync, early-sync, idle and reset frames.
      for (int k = 0; k < 600; k++) begin
         int sel;
         sel = int'($urandom_range(99));
         if (sel < 75)      send_word(int'($urandom_range(15)), 1'b1);
         else if (sel < 83) send_word(int'($urandom_range(15)), 1'b0);
         else if (sel < 91) begin
            cycle(1'b0, 1'b1, 1'($urandom_range(1)));
            for (int j = 0; j < int'($urandom_range(2)); j++)
               cycle(1'b0, 1'b0, 1'($urandom_range(1)));
         end else if (sel < 97) cycle(1'b0, 1'b0, 1'($urandom_range(1)));
         else cycle(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_frame_deserializer
